// File: rtl/home_render_controller_pkg.sv
// home_render_controller_pkg: shared states, command codes, colours and default geometry
package home_render_controller_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DRAW  = 2'd3;
  localparam logic FUNCT_LIGHT = 1'b1;
  localparam logic FUNCT_DOOR  = 1'b0;
  localparam logic [2:0] COL_BLACK       = 3'b000;
  localparam logic [2:0] COL_LIGHT_ON    = 3'b110;
  localparam logic [2:0] COL_LIGHT_OFF   = 3'b001;
  localparam logic [2:0] COL_DOOR_OPEN   = 3'b010;
  localparam logic [2:0] COL_DOOR_CLOSED = 3'b100;
  localparam int DEF_NUM_ROOMS  = 5;
  localparam int DEF_MAX_X      = 160;
  localparam int DEF_MAX_Y      = 120;
  localparam int DEF_X_W        = 8;
  localparam int DEF_Y_W        = 7;
  localparam int DEF_COLOUR_W   = 3;
  localparam int DEF_ICON       = 4;
  localparam int DEF_ROOM_X0    = 8;
  localparam int DEF_ROOM_PITCH = 30;
  localparam int DEF_ROOM_Y0    = 50;
  localparam int DEF_ICON_GAP   = 2;
  function automatic logic [2:0] icon_colour(input logic is_door, input logic on);
    return is_door ? (on ? COL_DOOR_OPEN : COL_DOOR_CLOSED) : (on ? COL_LIGHT_ON : COL_LIGHT_OFF);
  endfunction
endpackage

// File: rtl/home_render_controller_if.sv
// home_render_controller_if: command inputs and pixel/status outputs of the room renderer
interface home_render_controller_if
  import home_render_controller_pkg::*;
#(
  parameter int NUM_ROOMS = DEF_NUM_ROOMS,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int COLOUR_W  = DEF_COLOUR_W
);
  logic                 load;
  logic                 clear;
  logic [NUM_ROOMS-1:0] room_sel;
  logic                 funct;
  logic                 onoff;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [COLOUR_W-1:0]  colour;
  logic                 plot;
  logic                 busy;
  logic [NUM_ROOMS-1:0] light_state;
  logic [NUM_ROOMS-1:0] door_state;
  modport master (output load, clear, room_sel, funct, onoff,
                  input  x, y, colour, plot, busy, light_state, door_state);
  modport slave  (input  load, clear, room_sel, funct, onoff,
                  output x, y, colour, plot, busy, light_state, door_state);
endinterface

// File: rtl/home_render_controller_raster_counter.sv
// raster_counter: WIDTH x HEIGHT row-major sweep, wraps to origin after the last cell
module raster_counter #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int CW     = 8,
  parameter int RW     = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_done
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic w_last_col, w_last_row;
  assign w_last_col = r_col == CW'(WIDTH - 1);
  assign w_last_row = r_row == RW'(HEIGHT - 1);
  assign o_done = i_en & w_last_col & w_last_row;
  assign o_col = r_col;
  assign o_row = r_row;
  // advance column every enabled cycle, row on column wrap; restart returns to origin
  always_ff @(posedge clk)
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= w_last_col ? '0 : r_col + 1'b1;
      r_row <= !w_last_col ? r_row : w_last_row ? '0 : r_row + 1'b1;
    end
endmodule

// File: rtl/home_render_controller.sv
// home_render_controller: room light/door state with dirty-driven round-robin icon redraw
module home_render_controller
  import home_render_controller_pkg::*;
#(
  parameter int NUM_ROOMS  = DEF_NUM_ROOMS,
  parameter int MAX_X      = DEF_MAX_X,
  parameter int MAX_Y      = DEF_MAX_Y,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int COLOUR_W   = DEF_COLOUR_W,
  parameter int ICON       = DEF_ICON,
  parameter int ROOM_X0    = DEF_ROOM_X0,
  parameter int ROOM_PITCH = DEF_ROOM_PITCH,
  parameter int ROOM_Y0    = DEF_ROOM_Y0,
  parameter int ICON_GAP   = DEF_ICON_GAP
) (
  input logic clock,
  input logic reset,
  home_render_controller_if.slave bus
);
  if (ROOM_X0 + (NUM_ROOMS - 1) * ROOM_PITCH + ICON > MAX_X || ROOM_Y0 + 2 * ICON + ICON_GAP > MAX_Y ||
      NUM_ROOMS > 8 || NUM_ROOMS < 1) begin : g_bad_geometry
    $error("home_render_controller: room geometry does not fit the screen or coordinate widths");
  end
  logic [1:0] r_state, w_state_nxt;
  logic [NUM_ROOMS-1:0] r_light, r_door, r_dirty;
  logic [NUM_ROOMS-1:0] w_light_nxt, w_door_nxt, w_dirty_nxt, w_sel, w_scan_clr, w_rot;
  logic [2:0] r_rr, r_room, w_off, w_pick, w_rr_nxt;
  logic [3:0] w_sum;
  logic w_found, w_restart, w_clr_en, w_draw_en, w_clr_done, w_icon_done, w_plot, w_is_door, w_take;
  logic [X_W-1:0] w_cx, w_ix;
  logic [Y_W-1:0] w_cy, w_iy;
  assign w_restart = reset | bus.clear;
  assign w_clr_en  = r_state == ST_CLEAR;
  assign w_draw_en = r_state == ST_DRAW;
  raster_counter #(.WIDTH(MAX_X), .HEIGHT(MAX_Y), .CW(X_W), .RW(Y_W)) u_clear (
    .clk(clock), .rst(w_restart), .i_en(w_clr_en), .o_col(w_cx), .o_row(w_cy), .o_done(w_clr_done));
  // rows 0..ICON-1 sweep the light square, rows ICON..2*ICON-1 the door square
  raster_counter #(.WIDTH(ICON), .HEIGHT(2 * ICON), .CW(X_W), .RW(Y_W)) u_icon (
    .clk(clock), .rst(w_restart), .i_en(w_draw_en), .o_col(w_ix), .o_row(w_iy), .o_done(w_icon_done));
  assign w_rot = NUM_ROOMS'({r_dirty, r_dirty} >> r_rr);
  // lowest set bit of the dirty mask rotated to start at the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_off = '0;
    for (int k = NUM_ROOMS - 1; k >= 0; k--)
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off = 3'(k);
      end
  end
  assign w_sum = {1'b0, r_rr} + {1'b0, w_off};
  assign w_pick = (w_sum >= 4'(NUM_ROOMS)) ? 3'(w_sum - 4'(NUM_ROOMS)) : w_sum[2:0];
  assign w_rr_nxt = (w_pick == 3'(NUM_ROOMS - 1)) ? '0 : w_pick + 3'd1;
  assign w_take = (r_state == ST_SCAN) & w_found;
  assign w_sel = bus.load ? bus.room_sel : '0;
  assign w_scan_clr = w_take ? NUM_ROOMS'(1) << w_pick : '0;
  assign w_dirty_nxt = (bus.clear ? '0 : r_dirty & ~w_scan_clr) | w_sel;
  assign w_light_nxt = (bus.load && bus.funct == FUNCT_LIGHT) ?
                       (r_light & ~bus.room_sel) | (bus.room_sel & {NUM_ROOMS{bus.onoff}}) : r_light;
  assign w_door_nxt  = (bus.load && bus.funct == FUNCT_DOOR) ?
                       (r_door & ~bus.room_sel) | (bus.room_sel & {NUM_ROOMS{bus.onoff}}) : r_door;
  // a clear pulse preempts every state; otherwise sweep, pick, draw, repeat until nothing is dirty
  always_comb begin
    w_state_nxt = bus.clear ? ST_CLEAR :
                  r_state == ST_IDLE  ? (|w_dirty_nxt ? ST_SCAN : ST_IDLE) :
                  r_state == ST_CLEAR ? (w_clr_done ? ST_SCAN : ST_CLEAR) :
                  r_state == ST_SCAN  ? (w_found ? ST_DRAW : ST_IDLE) :
                  (w_icon_done ? ST_SCAN : ST_DRAW);
  end
  // state, room bits, dirty mask and round-robin pointer
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= ST_CLEAR;
      r_light <= '0;
      r_door  <= '0;
      r_dirty <= '1;
      r_rr    <= '0;
      r_room  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_light <= w_light_nxt;
      r_door  <= w_door_nxt;
      r_dirty <= w_dirty_nxt;
      r_rr    <= w_take ? w_rr_nxt : r_rr;
      r_room  <= w_take ? w_pick : r_room;
    end
  assign w_plot = ~reset & (w_clr_en | w_draw_en);
  assign w_is_door = w_iy >= Y_W'(ICON);
  assign bus.plot = w_plot;
  assign bus.x = !w_plot ? '0 : w_clr_en ? w_cx :
                 X_W'(ROOM_X0) + X_W'(r_room) * X_W'(ROOM_PITCH) + w_ix;
  assign bus.y = !w_plot ? '0 : w_clr_en ? w_cy :
                 Y_W'(ROOM_Y0) + w_iy + (w_is_door ? Y_W'(ICON_GAP) : '0);
  assign bus.colour = (!w_plot || w_clr_en) ? COLOUR_W'(COL_BLACK) :
                      COLOUR_W'(icon_colour(w_is_door, w_is_door ? r_door[r_room] : r_light[r_room]));
  assign bus.busy = ~reset & (r_state != ST_IDLE);
  assign bus.light_state = reset ? '0 : r_light;
  assign bus.door_state  = reset ? '0 : r_door;
endmodule

// File: tb/tb_home_render_controller.sv
// tb_home_render_controller: directed vectors and corner sequences for the room renderer
module tb_home_render_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  home_render_controller_if bus ();
  home_render_controller dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic [4:0] sel;
    logic       funct;
    logic       onoff;
    logic [4:0] exp_light;
    logic [4:0] exp_door;
    int         exp_plots;
  } vec_t;
  vec_t vecs[4];
  logic [17:0] q[$];
  int order[$];
  int checks = 0;
  int errors = 0;
  int rr = 0;
  int n;
  // capture every plotted pixel mid-cycle, away from the active edge
  always @(negedge clock) if (bus.plot) q.push_back({bus.x, bus.y, bus.colour});
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [17:0] px(input int i);
    return (i < q.size()) ? q[i] : 18'h3ffff;
  endfunction
  function automatic logic [17:0] icon_px(input int r, input int j, input logic lt, input logic dr);
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] c;
    xx = 8'(8 + 30 * r + j % 4);
    yy = 7'(50 + (j / 4) % 4 + (j >= 16 ? 6 : 0));
    c = (j >= 16) ? (dr ? 3'b010 : 3'b100) : (lt ? 3'b110 : 3'b001);
    return {xx, yy, c};
  endfunction
  task automatic check_icon(input string nm, input int base, input int r, input logic lt0,
                            input logic lt1, input logic dr, input int chg);
    int fb = 31;
    for (int j = 0; j < 32; j++)
      if (px(base + j) !== icon_px(r, j, j < chg ? lt0 : lt1, dr)) begin
        fb = j;
        break;
      end
    check(nm, px(base + fb), icon_px(r, fb, fb < chg ? lt0 : lt1, dr));
  endtask
  task automatic check_clear(input string nm, input int base);
    int fb = 19199;
    logic [17:0] e;
    for (int k = 0; k < 19200; k++) begin
      e = {8'(k % 160), 7'(k / 160), 3'b000};
      if (px(base + k) !== e) begin
        fb = k;
        break;
      end
    end
    check(nm, px(base + fb), {8'(fb % 160), 7'(fb / 160), 3'b000});
  endtask
  task automatic wait_idle(input int max, output int cyc);
    cyc = 0;
    while (bus.busy && cyc < max) begin
      tick;
      cyc++;
    end
    if (bus.busy) check("wait_idle_timeout", bus.busy, 0);
  endtask
  task automatic do_load(input logic [4:0] sel, input logic f, input logic o);
    bus.load = 1'b1;
    bus.room_sel = sel;
    bus.funct = f;
    bus.onoff = o;
    tick;
    bus.load = 1'b0;
  endtask
  initial begin
    bus.load = 1'b0;
    bus.clear = 1'b0;
    bus.room_sel = '0;
    bus.funct = 1'b0;
    bus.onoff = 1'b0;
    vecs[0] = '{5'b00100, 1'b1, 1'b1, 5'b00100, 5'b00000, 32};
    vecs[1] = '{5'b10010, 1'b0, 1'b1, 5'b00100, 5'b10010, 64};
    vecs[2] = '{5'b00110, 1'b1, 1'b0, 5'b00000, 5'b10010, 64};
    vecs[3] = '{5'b01001, 1'b1, 1'b1, 5'b01001, 5'b10010, 64};
    tick;
    tick;
    check("rst_plot", bus.plot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_light", bus.light_state, 0);
    check("rst_door", bus.door_state, 0);
    check("rst_xyc", {bus.x, bus.y, bus.colour}, 0);
    q.delete();
    reset = 1'b0;
    #1;
    check("init_busy", bus.busy, 1);
    check("init_first_px", {bus.plot, bus.x, bus.y, bus.colour}, {1'b1, 18'b0});
    wait_idle(25000, n);
    check("init_cycles", n, 19366);
    check("init_plots", q.size(), 19360);
    check_clear("init_clear", 0);
    for (int r = 0; r < 5; r++) check_icon($sformatf("init_room%0d", r), 19200 + 32 * r, r, 0, 0, 0, 0);
    for (int v = 0; v < 4; v++) begin
      q.delete();
      order.delete();
      do_load(vecs[v].sel, vecs[v].funct, vecs[v].onoff);
      check($sformatf("v%0d_light", v), bus.light_state, vecs[v].exp_light);
      check($sformatf("v%0d_door", v), bus.door_state, vecs[v].exp_door);
      for (int i = 0; i < 5; i++) if (vecs[v].sel[(rr + i) % 5]) order.push_back((rr + i) % 5);
      if (order.size() > 0) rr = (order[order.size() - 1] + 1) % 5;
      wait_idle(2000, n);
      check($sformatf("v%0d_cycles", v), n, 33 * order.size() + 1);
      check($sformatf("v%0d_plots", v), q.size(), vecs[v].exp_plots);
      for (int i = 0; i < order.size(); i++)
        check_icon($sformatf("v%0d_icon%0d_room%0d", v, i, order[i]), 32 * i, order[i],
                   vecs[v].exp_light[order[i]], vecs[v].exp_light[order[i]], vecs[v].exp_door[order[i]], 0);
    end
    q.delete();
    do_load(5'b00100, 1'b1, 1'b1);
    repeat (5) tick;
    do_load(5'b01010, 1'b1, 1'b1);
    check("rr_light", bus.light_state, 5'b01111);
    wait_idle(2000, n);
    check("rr_plots", q.size(), 96);
    check_icon("rr_room2", 0, 2, 1, 1, 0, 0);
    check_icon("rr_room3", 32, 3, 1, 1, 0, 0);
    check_icon("rr_room1", 64, 1, 1, 1, 1, 0);
    q.delete();
    do_load(5'b00001, 1'b1, 1'b0);
    repeat (10) tick;
    bus.clear = 1'b1;
    tick;
    bus.clear = 1'b0;
    check("abort_icon_px", q.size(), 10);
    check("abort_restart_px", {bus.plot, bus.x, bus.y, bus.colour}, {1'b1, 18'b0});
    q.delete();
    wait_idle(25000, n);
    check("abort_cycles", n, 19201);
    check("abort_plots", q.size(), 19200);
    check_clear("abort_clear", 0);
    check("abort_light", bus.light_state, 5'b01110);
    q.delete();
    bus.clear = 1'b1;
    do_load(5'b00001, 1'b0, 1'b1);
    bus.clear = 1'b0;
    check("lc_door", bus.door_state, 5'b10011);
    wait_idle(25000, n);
    check("lc_cycles", n, 19234);
    check("lc_plots", q.size(), 19232);
    check_clear("lc_clear", 0);
    check_icon("lc_room0", 19200, 0, 0, 0, 1, 0);
    q.delete();
    do_load(5'b10000, 1'b1, 1'b1);
    repeat (3) tick;
    do_load(5'b10000, 1'b1, 1'b0);
    wait_idle(2000, n);
    check("redraw_plots", q.size(), 64);
    check_icon("redraw_first", 0, 4, 1, 0, 1, 3);
    check_icon("redraw_second", 32, 4, 0, 0, 1, 0);
    check("redraw_light", bus.light_state, 5'b01110);
    do_load(5'b00010, 1'b1, 1'b0);
    repeat (3) tick;
    check("mid_plot_before", bus.plot, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_plot", bus.plot, 0);
    check("mid_rst_busy", bus.busy, 0);
    tick;
    reset = 1'b0;
    #1;
    check("mid_rst_restart", {bus.plot, bus.x, bus.y, bus.colour}, {1'b1, 18'b0});
    check("mid_rst_light", bus.light_state, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
